// File: rtl/conv2_buf_3ch.sv
// conv2_buf_3ch: three-channel 5x5 sliding-window generator feeding the conv2 calc stage.
// Optional feature macro CONV2_BUF_FRAME_DONE_EN adds a frame_done pulse on the last window.
module conv2_buf_3ch #(
  parameter int IN_W   = 12,
  parameter int IN_H   = 12,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in1,
  input  logic signed [DATA_W-1:0] data_in2,
  input  logic signed [DATA_W-1:0] data_in3,
  output logic signed [DATA_W-1:0] data_out1_0, data_out1_1, data_out1_2, data_out1_3, data_out1_4,
                                   data_out1_5, data_out1_6, data_out1_7, data_out1_8, data_out1_9,
                                   data_out1_10, data_out1_11, data_out1_12, data_out1_13, data_out1_14,
                                   data_out1_15, data_out1_16, data_out1_17, data_out1_18, data_out1_19,
                                   data_out1_20, data_out1_21, data_out1_22, data_out1_23, data_out1_24,
  output logic signed [DATA_W-1:0] data_out2_0, data_out2_1, data_out2_2, data_out2_3, data_out2_4,
                                   data_out2_5, data_out2_6, data_out2_7, data_out2_8, data_out2_9,
                                   data_out2_10, data_out2_11, data_out2_12, data_out2_13, data_out2_14,
                                   data_out2_15, data_out2_16, data_out2_17, data_out2_18, data_out2_19,
                                   data_out2_20, data_out2_21, data_out2_22, data_out2_23, data_out2_24,
  output logic signed [DATA_W-1:0] data_out3_0, data_out3_1, data_out3_2, data_out3_3, data_out3_4,
                                   data_out3_5, data_out3_6, data_out3_7, data_out3_8, data_out3_9,
                                   data_out3_10, data_out3_11, data_out3_12, data_out3_13, data_out3_14,
                                   data_out3_15, data_out3_16, data_out3_17, data_out3_18, data_out3_19,
                                   data_out3_20, data_out3_21, data_out3_22, data_out3_23, data_out3_24,
  output logic                     valid_out_buf
`ifdef CONV2_BUF_FRAME_DONE_EN
  ,
  output logic                     frame_done
`endif
);

  // The live input plus DEPTH stored pixels make up the 4*IN_W+5 entry window chain.
  localparam int DEPTH = 4 * IN_W + 4;
  localparam int CW    = $clog2(IN_W);
  localparam int RW    = $clog2(IN_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(4);
  localparam logic [RW-1:0] ROW_MIN  = RW'(4);

  logic [CW-1:0]             col_cnt;
  logic [RW-1:0]             row_cnt;
  logic signed [DATA_W-1:0]  din [3];
  logic signed [DATA_W-1:0]  chain [3][DEPTH];
  logic signed [DATA_W-1:0]  win_p0 [3][25];
  logic signed [DATA_W-1:0]  tap_p1 [3][25];
  logic                      vld_p0;
  logic                      vld_p1;

  assign din[0] = data_in1;
  assign din[1] = data_in2;
  assign din[2] = data_in3;

  // Stage p0: tap (r,c) sits (4-r) rows and (4-c) pixels behind the beat being accepted.
  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    for (genvar k = 0; k < 25; k++) begin : g_tap
      localparam int OFF = (4 - k / 5) * IN_W + (4 - k % 5);
      if (OFF == 0) begin : g_live
        assign win_p0[ch][k] = din[ch];
      end else begin : g_stored
        assign win_p0[ch][k] = chain[ch][OFF-1];
      end
    end
  end

  assign vld_p0 = valid_in && (row_cnt >= ROW_MIN) && (col_cnt >= COL_MIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        for (int i = 0; i < DEPTH; i++) chain[ch][i] <= '0;
        for (int k = 0; k < 25; k++) tap_p1[ch][k] <= '0;
      end
    end else if (valid_in) begin
      for (int ch = 0; ch < 3; ch++) begin
        chain[ch][0] <= din[ch];
        for (int i = 1; i < DEPTH; i++) chain[ch][i] <= chain[ch][i-1];
        for (int k = 0; k < 25; k++) tap_p1[ch][k] <= win_p0[ch][k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (valid_in) begin
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

`ifdef CONV2_BUF_FRAME_DONE_EN
  logic done_p1;

  always_ff @(posedge clk) begin
    if (rst) done_p1 <= 1'b0;
    else     done_p1 <= valid_in && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
  end

  assign frame_done = done_p1;
`endif

  // Stage p1: registered taps and strobe leave together.
  assign valid_out_buf = vld_p1;

  assign data_out1_0  = tap_p1[0][0];  assign data_out1_1  = tap_p1[0][1];  assign data_out1_2  = tap_p1[0][2];
  assign data_out1_3  = tap_p1[0][3];  assign data_out1_4  = tap_p1[0][4];  assign data_out1_5  = tap_p1[0][5];
  assign data_out1_6  = tap_p1[0][6];  assign data_out1_7  = tap_p1[0][7];  assign data_out1_8  = tap_p1[0][8];
  assign data_out1_9  = tap_p1[0][9];  assign data_out1_10 = tap_p1[0][10]; assign data_out1_11 = tap_p1[0][11];
  assign data_out1_12 = tap_p1[0][12]; assign data_out1_13 = tap_p1[0][13]; assign data_out1_14 = tap_p1[0][14];
  assign data_out1_15 = tap_p1[0][15]; assign data_out1_16 = tap_p1[0][16]; assign data_out1_17 = tap_p1[0][17];
  assign data_out1_18 = tap_p1[0][18]; assign data_out1_19 = tap_p1[0][19]; assign data_out1_20 = tap_p1[0][20];
  assign data_out1_21 = tap_p1[0][21]; assign data_out1_22 = tap_p1[0][22]; assign data_out1_23 = tap_p1[0][23];
  assign data_out1_24 = tap_p1[0][24];

  assign data_out2_0  = tap_p1[1][0];  assign data_out2_1  = tap_p1[1][1];  assign data_out2_2  = tap_p1[1][2];
  assign data_out2_3  = tap_p1[1][3];  assign data_out2_4  = tap_p1[1][4];  assign data_out2_5  = tap_p1[1][5];
  assign data_out2_6  = tap_p1[1][6];  assign data_out2_7  = tap_p1[1][7];  assign data_out2_8  = tap_p1[1][8];
  assign data_out2_9  = tap_p1[1][9];  assign data_out2_10 = tap_p1[1][10]; assign data_out2_11 = tap_p1[1][11];
  assign data_out2_12 = tap_p1[1][12]; assign data_out2_13 = tap_p1[1][13]; assign data_out2_14 = tap_p1[1][14];
  assign data_out2_15 = tap_p1[1][15]; assign data_out2_16 = tap_p1[1][16]; assign data_out2_17 = tap_p1[1][17];
  assign data_out2_18 = tap_p1[1][18]; assign data_out2_19 = tap_p1[1][19]; assign data_out2_20 = tap_p1[1][20];
  assign data_out2_21 = tap_p1[1][21]; assign data_out2_22 = tap_p1[1][22]; assign data_out2_23 = tap_p1[1][23];
  assign data_out2_24 = tap_p1[1][24];

  assign data_out3_0  = tap_p1[2][0];  assign data_out3_1  = tap_p1[2][1];  assign data_out3_2  = tap_p1[2][2];
  assign data_out3_3  = tap_p1[2][3];  assign data_out3_4  = tap_p1[2][4];  assign data_out3_5  = tap_p1[2][5];
  assign data_out3_6  = tap_p1[2][6];  assign data_out3_7  = tap_p1[2][7];  assign data_out3_8  = tap_p1[2][8];
  assign data_out3_9  = tap_p1[2][9];  assign data_out3_10 = tap_p1[2][10]; assign data_out3_11 = tap_p1[2][11];
  assign data_out3_12 = tap_p1[2][12]; assign data_out3_13 = tap_p1[2][13]; assign data_out3_14 = tap_p1[2][14];
  assign data_out3_15 = tap_p1[2][15]; assign data_out3_16 = tap_p1[2][16]; assign data_out3_17 = tap_p1[2][17];
  assign data_out3_18 = tap_p1[2][18]; assign data_out3_19 = tap_p1[2][19]; assign data_out3_20 = tap_p1[2][20];
  assign data_out3_21 = tap_p1[2][21]; assign data_out3_22 = tap_p1[2][22]; assign data_out3_23 = tap_p1[2][23];
  assign data_out3_24 = tap_p1[2][24];

endmodule

// File: tb/tb_conv2_buf_3ch.sv
// Bench for conv2_buf_3ch: directed table checks plus a frame-image window model on every cycle.
// Define CONV2_BUF_FRAME_DONE_EN for both files to exercise frame_done.
module tb_conv2_buf_3ch;
  localparam int IN_W = 12;
  localparam int IN_H = 12;
  localparam int DW   = 12;

  logic clk = 1'b0;
  logic rst, valid_in;
  logic signed [DW-1:0] data_in1, data_in2, data_in3;
  logic signed [DW-1:0] o1 [25];
  logic signed [DW-1:0] o2 [25];
  logic signed [DW-1:0] o3 [25];
  logic valid_out_buf;
`ifdef CONV2_BUF_FRAME_DONE_EN
  logic frame_done;
`endif

  always #5 clk = ~clk;

  conv2_buf_3ch #(.IN_W(IN_W), .IN_H(IN_H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .data_out1_0(o1[0]), .data_out1_1(o1[1]), .data_out1_2(o1[2]), .data_out1_3(o1[3]), .data_out1_4(o1[4]),
    .data_out1_5(o1[5]), .data_out1_6(o1[6]), .data_out1_7(o1[7]), .data_out1_8(o1[8]), .data_out1_9(o1[9]),
    .data_out1_10(o1[10]), .data_out1_11(o1[11]), .data_out1_12(o1[12]), .data_out1_13(o1[13]), .data_out1_14(o1[14]),
    .data_out1_15(o1[15]), .data_out1_16(o1[16]), .data_out1_17(o1[17]), .data_out1_18(o1[18]), .data_out1_19(o1[19]),
    .data_out1_20(o1[20]), .data_out1_21(o1[21]), .data_out1_22(o1[22]), .data_out1_23(o1[23]), .data_out1_24(o1[24]),
    .data_out2_0(o2[0]), .data_out2_1(o2[1]), .data_out2_2(o2[2]), .data_out2_3(o2[3]), .data_out2_4(o2[4]),
    .data_out2_5(o2[5]), .data_out2_6(o2[6]), .data_out2_7(o2[7]), .data_out2_8(o2[8]), .data_out2_9(o2[9]),
    .data_out2_10(o2[10]), .data_out2_11(o2[11]), .data_out2_12(o2[12]), .data_out2_13(o2[13]), .data_out2_14(o2[14]),
    .data_out2_15(o2[15]), .data_out2_16(o2[16]), .data_out2_17(o2[17]), .data_out2_18(o2[18]), .data_out2_19(o2[19]),
    .data_out2_20(o2[20]), .data_out2_21(o2[21]), .data_out2_22(o2[22]), .data_out2_23(o2[23]), .data_out2_24(o2[24]),
    .data_out3_0(o3[0]), .data_out3_1(o3[1]), .data_out3_2(o3[2]), .data_out3_3(o3[3]), .data_out3_4(o3[4]),
    .data_out3_5(o3[5]), .data_out3_6(o3[6]), .data_out3_7(o3[7]), .data_out3_8(o3[8]), .data_out3_9(o3[9]),
    .data_out3_10(o3[10]), .data_out3_11(o3[11]), .data_out3_12(o3[12]), .data_out3_13(o3[13]), .data_out3_14(o3[14]),
    .data_out3_15(o3[15]), .data_out3_16(o3[16]), .data_out3_17(o3[17]), .data_out3_18(o3[18]), .data_out3_19(o3[19]),
    .data_out3_20(o3[20]), .data_out3_21(o3[21]), .data_out3_22(o3[22]), .data_out3_23(o3[23]), .data_out3_24(o3[24]),
    .valid_out_buf(valid_out_buf)
`ifdef CONV2_BUF_FRAME_DONE_EN
    , .frame_done(frame_done)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int dones = 0;

  // Reference model: the current frame as a 2-D image; a window is read straight out of it.
  int img [3][IN_H][IN_W];
  int exp_tap [3][25];
  int m_row, m_col;
  bit exp_vld, exp_done, tap_known;

  typedef struct { int p; int ch; int tap; int want; } vec_t;
  vec_t tbl [$];

  function automatic int get(input int ch, input int k);
    case (ch)
      1:       return int'(o1[k]);
      2:       return int'(o2[k]);
      default: return int'(o3[k]);
    endcase
  endfunction

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input int a, input int b, input int c);
    if (r) begin
      m_row = 0; m_col = 0; exp_vld = 0; exp_done = 0; tap_known = 1;
      for (int ch = 0; ch < 3; ch++) for (int k = 0; k < 25; k++) exp_tap[ch][k] = 0;
    end else begin
      exp_vld = 0; exp_done = 0;
      if (v) begin
        img[0][m_row][m_col] = a;
        img[1][m_row][m_col] = b;
        img[2][m_row][m_col] = c;
        if (m_row >= 4 && m_col >= 4) begin
          exp_vld = 1; tap_known = 1;
          exp_done = (m_row == IN_H - 1) && (m_col == IN_W - 1);
          for (int ch = 0; ch < 3; ch++)
            for (int k = 0; k < 25; k++)
              exp_tap[ch][k] = img[ch][m_row - 4 + k / 5][m_col - 4 + k % 5];
        end else begin
          tap_known = 0;
        end
        m_col++;
        if (m_col == IN_W) begin
          m_col = 0; m_row++;
          if (m_row == IN_H) m_row = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int bad_ch, bad_k;
    bad_ch = -1; bad_k = 0;
    check_val("valid_out_buf", int'(valid_out_buf), int'(exp_vld));
    if (valid_out_buf) strobes++;
    if (exp_vld || tap_known) begin
      for (int ch = 0; ch < 3; ch++)
        for (int k = 0; k < 25; k++)
          if (bad_ch < 0 && get(ch + 1, k) != exp_tap[ch][k]) begin bad_ch = ch; bad_k = k; end
      checks++;
      if (bad_ch >= 0) begin
        errors++;
        $display("FAIL taps: data_out%0d_%0d got %0d expected %0d (cycle %0d)",
                 bad_ch + 1, bad_k, get(bad_ch + 1, bad_k), exp_tap[bad_ch][bad_k], cyc);
      end
    end
`ifdef CONV2_BUF_FRAME_DONE_EN
    check_val("frame_done", int'(frame_done), int'(exp_done));
    if (frame_done) dones++;
`endif
  endtask

  task automatic cycle(input logic r, input logic v, input int a, input int b, input int c);
    rst = r; valid_in = v;
    data_in1 = DW'(a); data_in2 = DW'(b); data_in3 = DW'(c);
    @(posedge clk);
    cyc++;
    model_step(r, v, int'(data_in1), int'(data_in2), int'(data_in3));
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, int'($urandom_range(4095)), int'($urandom_range(4095)), int'($urandom_range(4095)));
  endtask

  task automatic beat(input int p);
    cycle(1'b0, 1'b1, p, -p, 2047 - p);
  endtask

  task automatic run_frame(input int stall_pct, input bit rnd, input bit use_tbl);
    for (int p = 0; p < IN_H * IN_W; p++) begin
      for (int s = 0; s < 8 && int'($urandom_range(99)) < stall_pct; s++) idle();
      if (rnd) cycle(1'b0, 1'b1, int'($urandom_range(4095)), int'($urandom_range(4095)), int'($urandom_range(4095)));
      else     beat(p);
      if (use_tbl)
        foreach (tbl[i])
          if (tbl[i].p == p) begin
            if (tbl[i].ch == 0) check_val($sformatf("strobe_p%0d", p), int'(valid_out_buf), tbl[i].want);
            else check_val($sformatf("p%0d_ch%0d_tap%0d", p, tbl[i].ch, tbl[i].tap),
                           get(tbl[i].ch, tbl[i].tap), tbl[i].want);
          end
    end
  endtask

  initial begin
    int first;
    rst = 1'b1; valid_in = 1'b0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
    m_row = 0; m_col = 0; exp_vld = 0; exp_done = 0; tap_known = 0;

    tbl.push_back('{51, 0, 0, 0});
    tbl.push_back('{52, 0, 0, 1});
    tbl.push_back('{52, 1, 0, 0});
    tbl.push_back('{52, 1, 4, 4});
    tbl.push_back('{52, 1, 20, 48});
    tbl.push_back('{52, 1, 24, 52});
    tbl.push_back('{52, 2, 24, -52});
    tbl.push_back('{52, 3, 0, 2047});
    tbl.push_back('{59, 0, 0, 1});
    for (int p = 60; p < 64; p++) tbl.push_back('{p, 0, 0, 0});
    tbl.push_back('{64, 0, 0, 1});
    tbl.push_back('{64, 1, 0, 12});
    tbl.push_back('{64, 1, 24, 64});

    repeat (3) cycle(1'b1, 1'b0, 0, 0, 0);
    repeat (4) idle();

    strobes = 0; run_frame(0, 1'b0, 1'b1);
    check_val("strobes_frame", strobes, 64);

    strobes = 0; run_frame(50, 1'b0, 1'b0);
    check_val("strobes_stalled", strobes, 64);

    strobes = 0; run_frame(40, 1'b1, 1'b0);
    check_val("strobes_random", strobes, 64);

    strobes = 0; dones = 0;
    run_frame(0, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0);
    check_val("strobes_two_frames", strobes, 128);
`ifdef CONV2_BUF_FRAME_DONE_EN
    check_val("frame_done_pulses", dones, 2);
`endif

    for (int p = 0; p <= 30; p++) beat(p);
    cycle(1'b1, 1'b1, 31, -31, 2047 - 31);
    first = 0; strobes = 0;
    for (int p = 0; p < IN_H * IN_W; p++) begin
      beat(p);
      if (valid_out_buf && first == 0) begin
        first = p + 1;
        check_val("reset_restart_tap0", get(1, 0), 0);
      end
    end
    check_val("reset_restart_first_beat", first, 53);
    check_val("reset_restart_strobes", strobes, 64);
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
